// File: rtl/symbol_encoder_swlw.sv
// symbol_encoder_swlw: classifies up to two retiring sw/lw commits per cycle,
// encodes one 8-bit symbol per commit, buffers the symbols in a circular FIFO
// and drains one symbol per cycle with a run strobe into the swlw monitor.
// Optional feature macro: SWLW_ADDR_MATCH_EN builds the last-sw address
// register and comparator (symbol bit 2); without it bit 2 is always 0.
module symbol_encoder_swlw #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 64,
  parameter int WINDOW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               commit_valid,
  input  logic [1:0]               commit_is_sw,
  input  logic [1:0]               commit_is_lw,
  input  logic [ADDR_W-1:0]        commit_addr0,
  input  logic [ADDR_W-1:0]        commit_addr1,
  input  logic                     flush,
  output logic                     run,
  output logic [7:0]               symbols,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] WIN4 = 4'(WINDOW);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             run_reg, overflow_reg, mark_reg;
  logic [7:0]       symbols_reg;
  logic [3:0]       dist_reg, dist_next;
  logic             last_sw_valid_reg, sw_valid_next;

  logic [1:0] slot_sw, slot_lw, slot_other;
  logic [7:0] slot_sym [2];

`ifdef SWLW_ADDR_MATCH_EN
  logic [ADDR_W-1:0] last_sw_addr_reg, sw_addr_next;
  logic [ADDR_W-1:0] slot_addr [2];
  assign slot_addr[0] = commit_addr0;
  assign slot_addr[1] = commit_addr1;
`else
  logic unused_addr;
  assign unused_addr = ^{commit_addr0, commit_addr1};
`endif

  // Per-slot classification; sw wins when both sw and lw are flagged
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_decode
    assign slot_sw[gi]    = commit_valid[gi] & commit_is_sw[gi];
    assign slot_lw[gi]    = commit_valid[gi] & commit_is_lw[gi] & ~commit_is_sw[gi];
    assign slot_other[gi] = commit_valid[gi] & ~commit_is_sw[gi] & ~commit_is_lw[gi];
  end

  // Encode both slots in program order, chaining tracking state from slot 0 to slot 1
  always_comb begin
    dist_next     = dist_reg;
    sw_valid_next = last_sw_valid_reg;
`ifdef SWLW_ADDR_MATCH_EN
    sw_addr_next  = last_sw_addr_reg;
`endif
    for (int i = 0; i < 2; i++) begin
      slot_sym[i]    = 8'h00;
      slot_sym[i][0] = slot_sw[i];
      slot_sym[i][1] = slot_lw[i];
`ifdef SWLW_ADDR_MATCH_EN
      slot_sym[i][2] = slot_lw[i] & sw_valid_next & (slot_addr[i] == sw_addr_next);
`endif
      slot_sym[i][3] = slot_lw[i] & (dist_next < WIN4);
      slot_sym[i][4] = slot_other[i];
      slot_sym[i][5] = (i == 1);
      if (slot_sw[i]) begin
        dist_next     = 4'd0;
        sw_valid_next = 1'b1;
`ifdef SWLW_ADDR_MATCH_EN
        sw_addr_next  = slot_addr[i];
`endif
      end else if (commit_valid[i] && dist_next != 4'hF) begin
        dist_next = dist_next + 4'd1;
      end
    end
  end

  logic             pop, drop;
  logic [CNT_W-1:0] free_slots;
  logic [1:0]       n_valid, n_push;
  logic [7:0]       push_a, push_b;

  // Space check after this cycle's pop; the newest commits are the ones dropped
  always_comb begin
    pop        = (count_reg != '0);
    free_slots = CNT_W'(DEPTH) - count_reg + CNT_W'(pop);
    n_valid    = 2'(commit_valid[0]) + 2'(commit_valid[1]);
    if (free_slots >= CNT_W'(n_valid)) n_push = n_valid;
    else                               n_push = 2'(free_slots);
    drop   = (n_push != n_valid);
    push_a = commit_valid[0] ? slot_sym[0] : slot_sym[1];
    push_b = slot_sym[1];
    if (mark_reg) push_a[7] = 1'b1;
  end

  // Symbol storage: up to two writes per cycle at consecutive slots
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (n_push != 2'd0) mem[wr_ptr_reg] <= push_a;
      if (n_push == 2'd2) mem[wr_ptr_reg + 1'b1] <= push_b;
    end
  end

`ifdef SWLW_ADDR_MATCH_EN
  // Last store address; only meaningful while last_sw_valid is set
  always_ff @(posedge clk) begin
    if (!flush) last_sw_addr_reg <= sw_addr_next;
  end
`endif

  // Pointers, occupancy, output register, tracking and overflow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      run_reg           <= 1'b0;
      symbols_reg       <= 8'h00;
      overflow_reg      <= 1'b0;
      mark_reg          <= 1'b0;
      dist_reg          <= 4'hF;
      last_sw_valid_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      run_reg           <= 1'b0;
      symbols_reg       <= 8'h00;
      overflow_reg      <= 1'b0;
      mark_reg          <= 1'b0;
      dist_reg          <= 4'hF;
      last_sw_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg        <= wr_ptr_reg + PTR_W'(n_push);
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg         <= count_reg + CNT_W'(n_push) - CNT_W'(pop);
      run_reg           <= pop;
      symbols_reg       <= pop ? mem[rd_ptr_reg] : 8'h00;
      dist_reg          <= dist_next;
      last_sw_valid_reg <= sw_valid_next;
      if (drop) begin
        overflow_reg <= 1'b1;
        mark_reg     <= 1'b1;
      end else if (n_push != 2'd0) begin
        mark_reg     <= 1'b0;
      end
    end
  end

  assign run      = run_reg;
  assign symbols  = symbols_reg;
  assign overflow = overflow_reg;
  assign level    = count_reg;

endmodule

// File: tb/tb_symbol_encoder_swlw.sv
// Scoreboard bench for symbol_encoder_swlw (DEPTH=8, WINDOW=4).
// Expected symbols are queued at issue time; a negedge monitor compares each
// symbol presented with run=1 against the head of the queue.
module tb_symbol_encoder_swlw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  commit_valid = 2'b00;
  logic [1:0]  commit_is_sw = 2'b00;
  logic [1:0]  commit_is_lw = 2'b00;
  logic [63:0] commit_addr0 = '0;
  logic [63:0] commit_addr1 = '0;
  logic        flush = 1'b0;
  logic        run;
  logic [7:0]  symbols;
  logic        overflow;
  logic [3:0]  level;

`ifdef SWLW_ADDR_MATCH_EN
  localparam logic [7:0] M = 8'h04;
`else
  localparam logic [7:0] M = 8'h00;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  symbol_encoder_swlw #(.DEPTH(8), .ADDR_W(64), .WINDOW(4)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_is_sw(commit_is_sw), .commit_is_lw(commit_is_lw),
    .commit_addr0(commit_addr0), .commit_addr1(commit_addr1),
    .flush(flush), .run(run), .symbols(symbols), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Monitor: every symbol presented must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && run) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sym_unexpected: got %02h with no symbol expected", symbols);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (symbols !== e) begin
          errors++;
          $display("FAIL sym: got %02h required %02h", symbols, e);
        end else begin
          $display("sym ok %02h", symbols);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one commit cycle from posedge+1; returns at the following posedge+1
  task automatic issue(input logic [1:0] v, input logic [1:0] sw, input logic [1:0] lw,
                       input logic [63:0] a0, input logic [63:0] a1, input logic fl);
    commit_valid = v; commit_is_sw = sw; commit_is_lw = lw;
    commit_addr0 = a0; commit_addr1 = a1; flush = fl;
    @(posedge clk); #1;
    commit_valid = 2'b00; commit_is_sw = 2'b00; commit_is_lw = 2'b00; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(level == 0 && run == 1'b0) && n < 200) begin
      step();
      n++;
    end
    chk(name, 64'(n < 200), 64'd1);
  endtask

  initial begin
    // Reset values, checked while reset is held
    #1;
    chk("rst_run", 64'(run), 0);
    chk("rst_symbols", 64'(symbols), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_level", 64'(level), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    step();

    // T1: sw then lw at same address, then lw at another address
    issue(2'b01, 2'b01, 2'b00, 64'h100, 64'h0, 1'b0); exp_q.push_back(8'h01);
    chk("t1_lat_level", 64'(level), 1);
    chk("t1_lat_run", 64'(run), 0);
    issue(2'b01, 2'b00, 2'b01, 64'h100, 64'h0, 1'b0); exp_q.push_back(8'h0A | M);
    chk("t1_run", 64'(run), 1);
    issue(2'b01, 2'b00, 2'b01, 64'h104, 64'h0, 1'b0); exp_q.push_back(8'h0A);
    wait_idle("t1_idle");

    // T2: sw slot 0 and lw slot 1 in the same cycle
    issue(2'b11, 2'b01, 2'b10, 64'h200, 64'h200, 1'b0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h2A | M);
    chk("t2_level2", 64'(level), 2);
    step(); chk("t2_level1", 64'(level), 1);
    step(); chk("t2_level0", 64'(level), 0);
    wait_idle("t2_idle");

    // T3: distance window boundary and saturation (slot-1 sw with lw flag too)
    issue(2'b10, 2'b10, 2'b10, 64'h0, 64'h300, 1'b0); exp_q.push_back(8'h21);
    issue(2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10); exp_q.push_back(8'h30);
    issue(2'b01, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10);
    issue(2'b01, 2'b00, 2'b01, 64'h300, 64'h0, 1'b0); exp_q.push_back(8'h0A | M);
    issue(2'b01, 2'b00, 2'b01, 64'h300, 64'h0, 1'b0); exp_q.push_back(8'h02 | M);
    for (int i = 0; i < 12; i++) begin
      issue(2'b01, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10);
    end
    issue(2'b01, 2'b00, 2'b01, 64'h300, 64'h0, 1'b0); exp_q.push_back(8'h02 | M);
    wait_idle("t3_idle");

    // T4: two commits per cycle for 10 cycles overruns the 8-entry FIFO
    for (int i = 1; i <= 10; i++) begin
      issue(2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0);
      if (i <= 7) begin
        exp_q.push_back(8'h10); exp_q.push_back(8'h30);
      end else begin
        exp_q.push_back(i == 8 ? 8'h10 : 8'h90);
      end
      chk($sformatf("t4_overflow_%0d", i), 64'(overflow), 64'(i >= 8));
      chk($sformatf("t4_level_%0d", i), 64'(level), 64'(i + 1 > 8 ? 8 : i + 1));
      if (i >= 2) chk($sformatf("t4_run_%0d", i), 64'(run), 1);
    end
    for (int n = 0; n < 20 && level != 0; n++) begin
      chk("t4_run_drain", 64'(run), 1);
      step();
    end
    wait_idle("t4_idle");
    chk("t4_overflow_sticky", 64'(overflow), 1);

    // T5: build level 5 (first symbol carries the armed mark), then flush
    issue(2'b11, 2'b01, 2'b00, 64'h500, 64'h0, 1'b0);
    exp_q.push_back(8'h81); exp_q.push_back(8'h30);
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0);
      exp_q.push_back(8'h10); exp_q.push_back(8'h30);
    end
    chk("t5_level5", 64'(level), 5);
    issue(2'b01, 2'b00, 2'b00, 64'h0, 64'h0, 1'b1);
    chk("t5_flushed_pending", 64'(exp_q.size()), 5);
    exp_q.delete();
    chk("t5_run", 64'(run), 0);
    chk("t5_level", 64'(level), 0);
    chk("t5_overflow", 64'(overflow), 0);
    issue(2'b01, 2'b00, 2'b01, 64'h500, 64'h0, 1'b0); exp_q.push_back(8'h02);
    wait_idle("t5_idle");

    // T6: asynchronous reset mid-drain
    issue(2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10); exp_q.push_back(8'h30);
    issue(2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10); exp_q.push_back(8'h30);
    chk("t6_run_before", 64'(run), 1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_run", 64'(run), 0);
    chk("t6_symbols", 64'(symbols), 0);
    chk("t6_level", 64'(level), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_spurious_run", 64'(run), 0);
      step();
    end
    issue(2'b01, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0); exp_q.push_back(8'h10);
    wait_idle("t6_idle");

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/symbol_encoder_swlw.md
# symbol_encoder_swlw

Producer side of the sw/lw runtime-monitor symbol interface. Takes up to two retiring instructions per cycle from the commit stage, classifies each store-word/load-word, computes the address and distance predicates, and buffers the results. It then drains exactly one 8-bit symbol per cycle with a `run` strobe into the swlw automata top. The monitor has no backpressure, so this block owns all rate matching and overflow reporting.

## Interface
- `DEPTH`, 8: symbol FIFO entries; power of two, minimum 4.
- `ADDR_W`, 64: commit address width.
- `WINDOW`, 4: a lw is "near" when fewer than `WINDOW` instructions have retired since the last sw; range 1..15.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `commit_valid`  in  2  per-slot retire strobe; slot 0 is older.
- `commit_is_sw`  in  2  per-slot store-word flag.
- `commit_is_lw`  in  2  per-slot load-word flag.
- `commit_addr0`, `commit_addr1`  in  `ADDR_W`  effective address per slot.
- `flush`  in  1  synchronous clear of FIFO and tracking state.
- `run`  out  1  symbol valid this cycle; registered.
- `symbols`  out  8  encoded symbol; registered.
- `overflow`  out  1  sticky drop indicator; cleared only by `reset` or `flush`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Symbol bits:
  - [0] sw.
  - [1] lw.
  - [2] lw address equals the last sw address.
  - [3] lw is near (distance < `WINDOW`).
  - [4] non-memory or other instruction.
  - [5] commit slot index.
  - [6] reserved, 0.
  - [7] first symbol enqueued after one or more drops.
- Every valid commit produces a symbol. Both sw and lw set is illegal; sw takes priority.
- Tracking state: `last_sw_addr` (`ADDR_W`), `last_sw_valid`, and `dist` (4-bit, saturating at 15).
- Slots are processed in program order within a cycle:
  - A sw in slot 0 updates `last_sw_addr` and resets `dist` to 0 before slot 1 is evaluated.
  - Each non-sw commit increments `dist` (saturating).
  - Bit 2 requires `last_sw_valid`.
- Tracking state updates for dropped commits too, so predicates stay architecturally correct.
- FIFO: circular buffer with `DEPTH` entries and read/write pointers that wrap modulo `DEPTH`.
  - Up to 2 pushes per cycle, 1 pop per cycle.
  - Pop occurs whenever occupancy > 0.
  - Net level change per cycle = pushes − pop.
- Full handling:
  - Free space is computed after this cycle's pop.
  - If free < valid commits, the older commit(s) are kept and the newest are dropped.
  - Any drop sets `overflow` and arms `mark`.
  - `mark` sets bit 7 on the next accepted symbol, then clears.
- Output register:
  - When occupancy > 0, `run`=1 and `symbols` = head entry.
  - Otherwise `run`=0 and `symbols`=8'h00.
- `flush` empties the FIFO, clears `overflow`, `mark`, and `last_sw_valid`, and sets `dist` to 15. Commits in the same cycle as `flush` are discarded.
- All state update is gated by nothing else; the block runs every clock.

## Timing
- Reset values:
  - `run`=0, `symbols`=8'h00, `overflow`=0, `level`=0.
  - Pointers 0, `last_sw_valid`=0, `dist`=15, `mark`=0.
- Latency: a commit at edge t into an empty FIFO appears on `symbols` with `run`=1 from edge t+1.
- Two commits in one cycle appear on consecutive cycles, slot 0 first.
- Simultaneous push and pop at full: the pop frees one entry for this cycle's push.
- `reset` asserted mid-stream clears all state immediately, without waiting for a clock. The first `run` after deassertion requires a new commit.
- `level` reflects state after the edge, in the same cycle as `run`.

## Configuration
- `SWLW_ADDR_MATCH_EN` defined: `last_sw_addr` register and comparator are built; bit 2 is computed as above.
- Not defined: no address storage; bit 2 is constantly 0 and `commit_addr*` are ignored. All other bits and timing are unchanged.

## Test plan
- Single sw at addr 0x100 (slot 0), next cycle lw at 0x100 (slot 0): symbols 8'h01 then 8'h0E. With the macro undefined, the second symbol is 8'h0A.
- Same cycle: slot 0 sw 0x200, slot 1 lw 0x200: symbols 8'h01 then 8'h2E on consecutive cycles. `level` goes 2 then 1 then 0.
- sw, then 4 non-memory commits, then lw at same address (`WINDOW`=4): lw symbol 8'h06. `dist` saturates after 15 others.
- Two commits every cycle for 10 cycles (`DEPTH`=8): `overflow` rises on the first drop. The first accepted symbol after the drop has bit 7 set. `run` stays high continuously until drained.
- `flush` while `level`=5 with a concurrent commit: next cycle `run`=0, `level`=0, `overflow`=0. A following lw at the old sw address gives bit 2=0.
- Assert `reset` asynchronously mid-drain: outputs go to `run`=0, `symbols`=8'h00 without a clock edge. After release there is no spurious `run`.
